// File: rtl/dafx_address_pkg.sv
// DAFX register map entries owned by the channel mixer.
package dafx_address_pkg;

  localparam int unsigned AXI_ADDR_WIDTH_C = 12;

  localparam logic [AXI_ADDR_WIDTH_C-1:0] MIX_CLIP_ADDR       = 12'h0C8;
  localparam logic [AXI_ADDR_WIDTH_C-1:0] CLEAR_MIX_CLIP_ADDR = 12'h0CC;

endpackage

// File: rtl/dafx_mixer_pkg.sv
// Shared types, widths and saturation helpers for the DAFX channel mixer.
package dafx_mixer_pkg;

  localparam int unsigned AUDIO_WIDTH_C    = 24;
  localparam int unsigned GAIN_WIDTH_C     = 16;
  localparam int unsigned Q_BITS_C         = 12;
  localparam int unsigned NR_OF_CHANNELS_C = 4;

  localparam int unsigned PROD_WIDTH_C  = AUDIO_WIDTH_C + GAIN_WIDTH_C + 1;
  // Two extra bits so the four-term sum can never wrap.
  localparam int unsigned ACC_WIDTH_C   = AUDIO_WIDTH_C + GAIN_WIDTH_C + 3;
  localparam int unsigned GPROD_WIDTH_C = ACC_WIDTH_C + GAIN_WIDTH_C + 1;

  localparam logic signed [GPROD_WIDTH_C-1:0] SAT_MAX_C =
    {{(GPROD_WIDTH_C-AUDIO_WIDTH_C+1){1'b0}}, {(AUDIO_WIDTH_C-1){1'b1}}};
  localparam logic signed [GPROD_WIDTH_C-1:0] SAT_MIN_C =
    {{(GPROD_WIDTH_C-AUDIO_WIDTH_C+1){1'b1}}, {(AUDIO_WIDTH_C-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE_E,
    MAC_E,
    GAIN_E,
    OUT_E
  } mixer_state_t;

  function automatic logic is_clipped(input logic signed [GPROD_WIDTH_C-1:0] v);
    return (v > SAT_MAX_C) || (v < SAT_MIN_C);
  endfunction

  function automatic logic [AUDIO_WIDTH_C-1:0] saturate(
    input logic signed [GPROD_WIDTH_C-1:0] v
  );
    logic signed [GPROD_WIDTH_C-1:0] c;
    c = v;
    if (v > SAT_MAX_C) c = SAT_MAX_C;
    if (v < SAT_MIN_C) c = SAT_MIN_C;
    return c[AUDIO_WIDTH_C-1:0];
  endfunction

endpackage

// File: rtl/dafx_q_mul.sv
// Signed x unsigned Q-format multiply: (a * g) >>> Q_BITS_C with floor rounding.
module dafx_q_mul
  import dafx_mixer_pkg::*;
#(
  parameter int unsigned AWidth = ACC_WIDTH_C
) (
  input  logic signed [AWidth-1:0]              a_i,
  input  logic        [GAIN_WIDTH_C-1:0]        g_i,
  output logic signed [AWidth+GAIN_WIDTH_C:0]   q_o
);

  localparam int unsigned PWidth = AWidth + GAIN_WIDTH_C + 1;

  logic signed [PWidth-1:0] prod;

  always_comb begin
    prod = PWidth'(a_i) * PWidth'($signed({1'b0, g_i}));
    q_o  = prod >>> Q_BITS_C;
  end

endmodule

// File: rtl/dafx_channel_mixer.sv
// Four-channel stereo mixer: per-channel gain MAC, master gain, saturation, valid/ready out.
module dafx_channel_mixer
  import dafx_mixer_pkg::*;
(
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NR_OF_CHANNELS_C-1:0][AUDIO_WIDTH_C-1:0]  x_left,
  input  logic [NR_OF_CHANNELS_C-1:0][AUDIO_WIDTH_C-1:0]  x_right,
  input  logic                                            x_valid,
  output logic                                            x_ready,
  input  logic [NR_OF_CHANNELS_C-1:0][GAIN_WIDTH_C-1:0]   cr_mix_channel_gain,
  input  logic [GAIN_WIDTH_C-1:0]                         cr_mix_output_gain,
  input  logic                                            cmd_clear_mix_clip,
  output logic [AUDIO_WIDTH_C-1:0]                        y_left,
  output logic [AUDIO_WIDTH_C-1:0]                        y_right,
  output logic                                            y_valid,
  input  logic                                            y_ready,
  output logic [AUDIO_WIDTH_C-1:0]                        sr_mix_out_left,
  output logic [AUDIO_WIDTH_C-1:0]                        sr_mix_out_right,
  output logic                                            sr_mix_clip
);

  mixer_state_t state_q, state_d;
  logic [1:0]   k_q, k_d;

  logic [NR_OF_CHANNELS_C-1:0][AUDIO_WIDTH_C-1:0] xl_q, xl_d, xr_q, xr_d;
  logic [NR_OF_CHANNELS_C-1:0][GAIN_WIDTH_C-1:0]  g_q, g_d;
  logic [GAIN_WIDTH_C-1:0]                        og_q, og_d;

  logic signed [ACC_WIDTH_C-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;

  logic                     x_ready_q, x_ready_d;
  logic                     y_valid_q, y_valid_d;
  logic [AUDIO_WIDTH_C-1:0] y_left_q, y_left_d, y_right_q, y_right_d;
  logic [AUDIO_WIDTH_C-1:0] sr_l_q, sr_l_d, sr_r_q, sr_r_d;
  logic                     clip_q, clip_d;

  logic signed [ACC_WIDTH_C-1:0]   mul_a_l, mul_a_r;
  logic        [GAIN_WIDTH_C-1:0]  mul_g;
  logic signed [GPROD_WIDTH_C-1:0] mul_l, mul_r;

  // Multipliers are shared: channel samples during MAC, accumulators during GAIN.
  always_comb begin
    mul_a_l = ACC_WIDTH_C'($signed(xl_q[k_q]));
    mul_a_r = ACC_WIDTH_C'($signed(xr_q[k_q]));
    mul_g   = g_q[k_q];
    if (state_q == GAIN_E) begin
      mul_a_l = acc_l_q;
      mul_a_r = acc_r_q;
      mul_g   = og_q;
    end
  end

  dafx_q_mul #(
    .AWidth(ACC_WIDTH_C)
  ) u_q_mul_l (
    .a_i(mul_a_l),
    .g_i(mul_g),
    .q_o(mul_l)
  );

  dafx_q_mul #(
    .AWidth(ACC_WIDTH_C)
  ) u_q_mul_r (
    .a_i(mul_a_r),
    .g_i(mul_g),
    .q_o(mul_r)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    g_d       = g_q;
    og_d      = og_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    y_valid_d = y_valid_q;
    y_left_d  = y_left_q;
    y_right_d = y_right_q;
    sr_l_d    = sr_l_q;
    sr_r_d    = sr_r_q;
    // Clear first so a coincident clip in GAIN_E wins.
    clip_d    = clip_q & ~cmd_clear_mix_clip;

    unique case (state_q)
      IDLE_E: begin
        if (x_valid && x_ready_q) begin
          xl_d    = x_left;
          xr_d    = x_right;
          g_d     = cr_mix_channel_gain;
          og_d    = cr_mix_output_gain;
          acc_l_d = '0;
          acc_r_d = '0;
          k_d     = '0;
          state_d = MAC_E;
        end
      end
      MAC_E: begin
        acc_l_d = acc_l_q + $signed(mul_l[ACC_WIDTH_C-1:0]);
        acc_r_d = acc_r_q + $signed(mul_r[ACC_WIDTH_C-1:0]);
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) state_d = GAIN_E;
      end
      GAIN_E: begin
        y_left_d  = saturate(mul_l);
        y_right_d = saturate(mul_r);
        sr_l_d    = y_left_d;
        sr_r_d    = y_right_d;
        y_valid_d = 1'b1;
        if (is_clipped(mul_l) || is_clipped(mul_r)) clip_d = 1'b1;
        state_d   = OUT_E;
      end
      OUT_E: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = IDLE_E;
        end
      end
      default: state_d = IDLE_E;
    endcase

    x_ready_d = (state_d == IDLE_E);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_E;
      k_q       <= '0;
      xl_q      <= '0;
      xr_q      <= '0;
      g_q       <= '0;
      og_q      <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_left_q  <= '0;
      y_right_q <= '0;
      sr_l_q    <= '0;
      sr_r_q    <= '0;
      clip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      xl_q      <= xl_d;
      xr_q      <= xr_d;
      g_q       <= g_d;
      og_q      <= og_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      x_ready_q <= x_ready_d;
      y_valid_q <= y_valid_d;
      y_left_q  <= y_left_d;
      y_right_q <= y_right_d;
      sr_l_q    <= sr_l_d;
      sr_r_q    <= sr_r_d;
      clip_q    <= clip_d;
    end
  end

  assign x_ready          = x_ready_q;
  assign y_valid          = y_valid_q;
  assign y_left           = y_left_q;
  assign y_right          = y_right_q;
  assign sr_mix_out_left  = sr_l_q;
  assign sr_mix_out_right = sr_r_q;
  assign sr_mix_clip      = clip_q;

endmodule

// File: tb/tb_dafx_channel_mixer.sv
// Table-driven bench for dafx_channel_mixer with an expected-result queue.
module tb_dafx_channel_mixer;

  logic                  clk;
  logic                  rst_n;
  logic [3:0][23:0]      x_left, x_right;
  logic                  x_valid, x_ready;
  logic [3:0][15:0]      cr_mix_channel_gain;
  logic [15:0]           cr_mix_output_gain;
  logic                  cmd_clear_mix_clip;
  logic [23:0]           y_left, y_right;
  logic                  y_valid, y_ready;
  logic [23:0]           sr_mix_out_left, sr_mix_out_right;
  logic                  sr_mix_clip;

  dafx_channel_mixer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .x_left             (x_left),
    .x_right            (x_right),
    .x_valid            (x_valid),
    .x_ready            (x_ready),
    .cr_mix_channel_gain(cr_mix_channel_gain),
    .cr_mix_output_gain (cr_mix_output_gain),
    .cmd_clear_mix_clip (cmd_clear_mix_clip),
    .y_left             (y_left),
    .y_right            (y_right),
    .y_valid            (y_valid),
    .y_ready            (y_ready),
    .sr_mix_out_left    (sr_mix_out_left),
    .sr_mix_out_right   (sr_mix_out_right),
    .sr_mix_clip        (sr_mix_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] l;
    logic [3:0][31:0] r;
    logic [3:0][31:0] g;
    int               og;
    int               yl;
    int               yr;
    bit               clip;
  } vec_t;

  typedef struct {
    int yl;
    int yr;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [3:0][31:0] all4(input int v);
    return {v, v, v, v};
  endfunction

  function automatic logic [3:0][31:0] ch(input int idx, input int v);
    logic [3:0][31:0] a;
    a = '0;
    a[idx] = v;
    return a;
  endfunction

  function automatic vec_t mk(input logic [3:0][31:0] l, input logic [3:0][31:0] r,
                              input logic [3:0][31:0] g, input int og, input int yl,
                              input int yr, input bit clip);
    vec_t v;
    v.l = l; v.r = r; v.g = g; v.og = og; v.yl = yl; v.yr = yr; v.clip = clip;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      x_left[i]              = v.l[i][23:0];
      x_right[i]             = v.r[i][23:0];
      cr_mix_channel_gain[i] = v.g[i][15:0];
    end
    cr_mix_output_gain = v.og[15:0];
  endtask

  // Drives one frame; clr_cycle pulses the clip clear in that cycle after accept,
  // hold keeps y_ready low that many cycles, g0_zero_mid rewrites ch0 gain in MAC.
  task automatic do_frame(input vec_t v, input string tag, input int clr_cycle,
                          input int hold, input bit g0_zero_mid);
    int   cycles;
    exp_t e;
    logic [23:0] hl, hr;
    @(negedge clk);
    apply(v);
    x_valid = 1'b1;
    cycles = 0;
    while (!x_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_accept"}, 64'(x_ready), 64'd1);
    e.yl = v.yl;
    e.yr = v.yr;
    sb.push_back(e);
    cycles = 0;
    while (!y_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
      x_valid = 1'b0;
      cmd_clear_mix_clip = (cycles == clr_cycle);
      if (g0_zero_mid && cycles == 1) cr_mix_channel_gain[0] = '0;
      if (!y_valid) check({tag, "_xready_busy"}, 64'(x_ready), 64'd0);
    end
    cmd_clear_mix_clip = 1'b0;
    check({tag, "_latency"}, cycles, 6);
    hl = y_left;
    hr = y_right;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(y_valid), 64'd1);
      check({tag, "_hold_xready"}, 64'(x_ready), 64'd0);
      check({tag, "_hold_stable"}, 64'({y_left, y_right}), 64'({hl, hr}));
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_y_left"}, $signed(y_left), e.yl);
      check({tag, "_y_right"}, $signed(y_right), e.yr);
      check({tag, "_sr_left"}, $signed(sr_mix_out_left), e.yl);
      check({tag, "_sr_right"}, $signed(sr_mix_out_right), e.yr);
    end else begin
      check({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd1);
    end
    check({tag, "_clip"}, 64'(sr_mix_clip), 64'(v.clip));
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    check({tag, "_y_valid_drop"}, 64'(y_valid), 64'd0);
    check({tag, "_x_ready_back"}, 64'(x_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   cycles;
    vec_t v;
    rst_n = 1'b0;
    x_left = '0; x_right = '0; x_valid = 1'b0;
    cr_mix_channel_gain = '0; cr_mix_output_gain = '0;
    cmd_clear_mix_clip = 1'b0; y_ready = 1'b0;

    vecs[0] = mk(ch(0, 1000), ch(0, -1000), all4(4096), 4096, 1000, -1000, 1'b0);
    vecs[1] = mk(all4(100000), all4(100000), all4(4096), 4096, 400000, 400000, 1'b0);
    vecs[2] = mk(ch(0, -3), ch(0, 3), ch(0, 2048), 4096, -2, 1, 1'b0);
    vecs[3] = mk(all4(8388607), all4(-8388608), all4(4096), 4096, 8388607, -8388608, 1'b1);
    vecs[4] = mk(ch(1, 5), ch(1, -5), all4(4096), 2048, 2, -3, 1'b1);
    vecs[5] = mk(ch(2, 100), ch(2, -1), ch(2, 65535), 4096, 1599, -16, 1'b1);
    vecs[6] = mk(ch(2, 100), ch(2, -1), ch(2, 65535), 65535, 25583, -256, 1'b1);
    vecs[7] = mk(all4(12345), all4(-777), all4(0), 4096, 0, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("reset_x_ready", 64'(x_ready), 64'd0);
    check("reset_y_valid", 64'(y_valid), 64'd0);
    check("reset_y", 64'({y_left, y_right}), 64'd0);
    check("reset_sr", 64'({sr_mix_out_left, sr_mix_out_right}), 64'd0);
    check("reset_clip", 64'(sr_mix_clip), 64'd0);
    rst_n = 1'b1;
    check("release_x_ready_low", 64'(x_ready), 64'd0);
    @(negedge clk);
    check("release_x_ready_high", 64'(x_ready), 64'd1);

    for (int i = 0; i < 8; i++) do_frame(vecs[i], $sformatf("vec%0d", i), -1, 0, 1'b0);

    // Lone clear, then clear coinciding with a clipping GAIN_E, then lone clear.
    @(negedge clk); cmd_clear_mix_clip = 1'b1;
    @(negedge clk); cmd_clear_mix_clip = 1'b0;
    check("lone_clear_1", 64'(sr_mix_clip), 64'd0);
    do_frame(vecs[3], "clip_vs_clear", 5, 0, 1'b0);
    @(negedge clk); cmd_clear_mix_clip = 1'b1;
    @(negedge clk); cmd_clear_mix_clip = 1'b0;
    check("lone_clear_2", 64'(sr_mix_clip), 64'd0);

    // Backpressure with a mid-frame gain write; next frame picks up gain 0.
    do_frame(vecs[0], "hold_old_gain", -1, 10, 1'b1);
    v = mk(ch(0, 1000), ch(0, -1000), ch(1, 4096), 4096, 0, 0, 1'b0);
    do_frame(v, "new_gain_zero", -1, 0, 1'b0);

    // Set the clip flag so the reset check below is meaningful.
    do_frame(vecs[3], "pre_reset_clip", -1, 0, 1'b0);

    // Reset in the middle of MAC_E.
    @(negedge clk);
    apply(vecs[1]);
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_x_ready", 64'(x_ready), 64'd0);
    check("midrst_y_valid", 64'(y_valid), 64'd0);
    check("midrst_y", 64'({y_left, y_right}), 64'd0);
    check("midrst_sr", 64'({sr_mix_out_left, sr_mix_out_right}), 64'd0);
    check("midrst_clip", 64'(sr_mix_clip), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_release_x_ready_low", 64'(x_ready), 64'd0);
    @(negedge clk);
    check("midrst_release_x_ready_high", 64'(x_ready), 64'd1);
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (y_valid) cycles++;
    end
    check("midrst_no_y_valid", cycles, 0);

    do_frame(vecs[2], "after_reset", -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
